// File: rtl/flappy_pkg.sv
// flappy_pkg: values shared by the wall scroller, collision checker and renderer.
// Holds the playfield geometry defaults, the hole top offset, the start position
// of the wall and the wall FSM state encoding, so every consumer agrees on them.
package flappy_pkg;

    localparam int SCREEN_W_DEF = 160;  // screen width in pixels
    localparam int WALL_W_DEF   = 16;   // wall width in pixels
    localparam int GAP_H_DEF    = 40;   // vertical hole height
    localparam int HOLE_TOP_OFS = 8;    // smallest possible hole top row
    localparam int START_TOPY   = 40;   // hole top row of the first wall

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCROLL  = 2'd1,
        RESPAWN = 2'd2
    } wall_state_t;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal, period 255).
// Advances on every rising clock edge; synchronous active-high reset loads seed.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, loads seed
//   seed  - reset value; a zero seed is replaced by 1 so the register never locks up
//   q     - current LFSR value, never zero
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic fb;

    // Taps for x^8, x^6, x^5, x^4 sit at bits 7, 5, 4, 3 of a left-shifting register.
    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/wall_scroller.sv
// wall_scroller: moves a single wall with a hole leftward across the screen, one
// STEP per frame tick, and respawns it at the right edge with a pseudo-random
// hole position once it has reached the left edge.
// Ports:
//   clk          - system clock
//   reset        - synchronous active-high reset (highest priority)
//   frame_tick   - one-cycle pulse per video frame
//   enable       - game running; low freezes the wall
//   restart      - one-cycle pulse: reload start position, return to IDLE
//   wall_xleft   - registered left column of the wall (inclusive)
//   wall_xright  - registered right column of the wall (inclusive)
//   wall_topy    - registered row just above the hole
//   wall_bottomy - registered row just below the hole
//   wall_passed  - one-cycle pulse when a new wall spawns
//   dbg_state    - current FSM state (wall_state_t encoding)
//   dbg_lfsr     - current LFSR value
module wall_scroller
    import flappy_pkg::*;
#(
    parameter int         SCREEN_W  = SCREEN_W_DEF,
    parameter int         WALL_W    = WALL_W_DEF,
    parameter int         GAP_H     = GAP_H_DEF,
    parameter int         STEP      = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       restart,
    output logic [7:0] wall_xleft,
    output logic [7:0] wall_xright,
    output logic [7:0] wall_topy,
    output logic [7:0] wall_bottomy,
    output logic       wall_passed,
    output logic [1:0] dbg_state,
    output logic [7:0] dbg_lfsr
);

    localparam logic [7:0] X_START   = 8'(SCREEN_W - WALL_W);
    localparam logic [7:0] X_RIGHT   = 8'(WALL_W - 1);
    localparam logic [7:0] GAP_B     = 8'(GAP_H);
    localparam logic [7:0] STEP_B    = 8'(STEP);
    localparam logic [7:0] TOP_OFS_B = 8'(HOLE_TOP_OFS);
    localparam logic [7:0] TOP_START = 8'(START_TOPY);

    wall_state_t state, state_n;
    logic [7:0]  xleft_n;
    logic [7:0]  topy_n;
    logic        passed_n;
    logic [7:0]  lfsr_q;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign dbg_state = state;
    assign dbg_lfsr  = lfsr_q;

    always_comb begin
        state_n  = state;
        xleft_n  = wall_xleft;
        topy_n   = wall_topy;
        passed_n = 1'b0;
        if (restart) begin
            state_n = IDLE;
            xleft_n = X_START;
            topy_n  = TOP_START;
        end else begin
            case (state)
                IDLE: begin
                    xleft_n = X_START;
                    topy_n  = TOP_START;
                    if (enable) state_n = SCROLL;
                end
                SCROLL: begin
                    // A wall that can no longer move a full step is retired
                    // rather than clipped, so xleft never wraps below zero.
                    if (enable && frame_tick) begin
                        if (wall_xleft >= STEP_B) xleft_n = wall_xleft - STEP_B;
                        else                      state_n = RESPAWN;
                    end
                end
                RESPAWN: begin
                    xleft_n  = X_START;
                    topy_n   = TOP_OFS_B + {2'b00, lfsr_q[5:0]};
                    passed_n = 1'b1;
                    state_n  = SCROLL;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Derived extents are registered from the next-state values so all outputs
    // change together on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wall_xleft   <= X_START;
            wall_xright  <= X_START + X_RIGHT;
            wall_topy    <= TOP_START;
            wall_bottomy <= TOP_START + GAP_B;
            wall_passed  <= 1'b0;
        end else begin
            state        <= state_n;
            wall_xleft   <= xleft_n;
            wall_xright  <= xleft_n + X_RIGHT;
            wall_topy    <= topy_n;
            wall_bottomy <= topy_n + GAP_B;
            wall_passed  <= passed_n;
        end
    end

endmodule

// File: tb/tb_wall_scroller.sv
// tb_wall_scroller: directed and randomized checks of wall_scroller against a
// behavioural model of the wall position, hole placement and LFSR sequence.
module tb_wall_scroller;
    import flappy_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] wall_xleft, wall_xright, wall_topy, wall_bottomy;
    logic       wall_passed;
    logic [1:0] dbg_state;
    logic [7:0] dbg_lfsr;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int          m_x, m_top, m_passed, m_lfsr;
    wall_state_t m_state;
    logic [7:0]  exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    wall_scroller dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .restart      (restart),
        .wall_xleft   (wall_xleft),
        .wall_xright  (wall_xright),
        .wall_topy    (wall_topy),
        .wall_bottomy (wall_bottomy),
        .wall_passed  (wall_passed),
        .dbg_state    (dbg_state),
        .dbg_lfsr     (dbg_lfsr)
    );

    function automatic int lfsr_next(input int v);
        return ((v * 2) % 256) + ($countones(v & 8'hB8) % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, using the inputs applied before it.
    task automatic model_edge();
        if (reset) begin
            m_state = IDLE; m_x = 144; m_top = 40; m_passed = 0;
            m_lfsr = 8'hA5;
        end else begin
            m_passed = 0;
            if (restart) begin
                m_state = IDLE; m_x = 144; m_top = 40;
            end else if (m_state == IDLE) begin
                if (enable) m_state = SCROLL;
            end else if (m_state == SCROLL) begin
                if (enable && frame_tick) begin
                    if (m_x >= 1) m_x = m_x - 1;
                    else          m_state = RESPAWN;
                end
            end else begin
                m_x = 160 - 16;
                m_top = 8 + (m_lfsr % 64);
                m_passed = 1;
                m_state = SCROLL;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic check_model();
        chk("xleft",   wall_xleft,   m_x);
        chk("xright",  wall_xright,  m_x + 15);
        chk("topy",    wall_topy,    m_top);
        chk("bottomy", wall_bottomy, m_top + 40);
        chk("passed",  wall_passed,  m_passed);
        chk("state",   dbg_state,    m_state);
        chk("lfsr",    dbg_lfsr,     m_lfsr);
    endtask

    // driver: apply inputs on the falling edge, check just after the rising edge
    task automatic step(input logic r, input logic rs, input logic en, input logic tk);
        @(negedge clk);
        reset = r; restart = rs; enable = en; frame_tick = tk;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        // reset and start
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("reset_xleft", wall_xleft, 144);
        chk("reset_lfsr", dbg_lfsr, 8'hA5);
        chk("reset_state", dbg_state, IDLE);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_state", dbg_state, SCROLL);
        chk("start_xright", wall_xright, 159);
        chk("start_topy", wall_topy, 40);
        chk("start_bottomy", wall_bottomy, 80);
        chk("start_passed", wall_passed, 0);

        // scroll and freeze
        ticks(10);
        chk("scroll_xleft", wall_xleft, 134);
        chk("scroll_xright", wall_xright, 149);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("freeze_xleft", wall_xleft, 134);

        // wrap and respawn
        ticks(134);
        chk("wrap_xleft0", wall_xleft, 0);
        ticks(1);
        chk("wrap_respawn", dbg_state, RESPAWN);
        chk("wrap_hold", wall_xleft, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("respawn_xleft", wall_xleft, 144);
        chk("respawn_passed", wall_passed, 1);
        chk("respawn_top_range", (wall_topy >= 8 && wall_topy <= 71), 1);
        chk("respawn_bottom", wall_bottomy, wall_topy + 8'd40);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("passed_single", wall_passed, 0);

        // restart beats a simultaneous frame tick
        ticks(94);
        chk("pre_restart_x", wall_xleft, 50);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("restart_x", wall_xleft, 144);
        chk("restart_state", dbg_state, IDLE);
        chk("restart_passed", wall_passed, 0);

        // LFSR period from the seed
        step(1'b1, 1'b0, 1'b0, 1'b0);
        begin
            int v;
            v = 8'hA5;
            for (int i = 0; i < 255; i++) begin
                v = lfsr_next(v);
                exp_q.push_back(v[7:0]);
            end
        end
        for (int i = 0; i < 255; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("lfsr_seq", dbg_lfsr, exp_q.pop_front());
            chk("lfsr_nonzero", (dbg_lfsr != 8'h00), 1);
            if (i == 254) chk("lfsr_period", dbg_lfsr, 8'hA5);
        end

        // reset during RESPAWN
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(145);
        chk("pre_reset_respawn", dbg_state, RESPAWN);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_resp_x", wall_xleft, 144);
        chk("rst_resp_top", wall_topy, 40);
        chk("rst_resp_passed", wall_passed, 0);
        chk("rst_resp_state", dbg_state, IDLE);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) == 0,
                 $urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) != 0,
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wall_scroller.md
WALL_SCROLLER -- requirements
Module: wall_scroller

Interface
REQ-001 Parameters SHALL be: SCREEN_W, 160, screen width in pixels; WALL_W, 16, wall width; GAP_H, 40, vertical hole height; STEP, 1, pixels moved per frame tick; LFSR_SEED, 8'hA5, nonzero LFSR reset value.
REQ-002 clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse per video frame.
REQ-005 enable  input  1  high while the game is running; low freezes the wall.
REQ-006 restart  input  1  one-cycle pulse that reloads the start position and returns to IDLE.
REQ-007 wall_xleft, wall_xright  output  8 each  registered horizontal wall extent, inclusive.
REQ-008 wall_topy, wall_bottomy  output  8 each  registered hole extent; the hole is rows topy+1 .. bottomy-1.
REQ-009 wall_passed  output  1  one-cycle pulse when a wall leaves the screen and a new wall spawns.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SCROLL and RESPAWN.
REQ-011 IDLE SHALL hold all outputs at start values and go to SCROLL on the first cycle with enable=1.
REQ-012 In SCROLL, when frame_tick=1 and enable=1 and wall_xleft >= STEP, wall_xleft SHALL decrease by STEP on that edge.
REQ-013 In SCROLL, when frame_tick=1 and enable=1 and wall_xleft < STEP, the FSM SHALL go to RESPAWN without moving.
REQ-014 In SCROLL with enable=0, all outputs SHALL hold, regardless of frame_tick.
REQ-015 RESPAWN SHALL last exactly one cycle and perform these actions:
  - set wall_xleft = SCREEN_W - WALL_W;
  - set wall_topy = 8 + lfsr[5:0] (range 8..71);
  - set wall_bottomy = wall_topy + GAP_H (range 48..111);
  - pulse wall_passed;
  - return to SCROLL.
REQ-016 wall_xright SHALL always equal wall_xleft + WALL_W - 1, with a maximum of 159, so it never overflows 8 bits.
REQ-017 wall_bottomy SHALL always equal wall_topy + GAP_H.
REQ-018 A frame_tick arriving in RESPAWN or IDLE SHALL be ignored and not queued.
REQ-019 The LFSR SHALL be 8-bit Fibonacci (x^8+x^6+x^5+x^4+1), advance every clock cycle independent of state, and never reach zero.
REQ-020 restart=1 SHALL take priority over frame_tick, enable and RESPAWN, and on the next edge:
  - reload start values;
  - go to IDLE;
  - suppress wall_passed.
  The LFSR SHALL NOT be reseeded by restart.
REQ-021 Start values SHALL be: wall_xleft=144, wall_xright=159, wall_topy=40, wall_bottomy=80.
REQ-022 All outputs SHALL be registered, and wall_passed SHALL be high for no more than one consecutive cycle.

Reset
REQ-023 When reset=1 on a rising edge, the block SHALL apply all of the following:
  - state = IDLE;
  - outputs = start values;
  - wall_passed = 0;
  - lfsr = LFSR_SEED.
REQ-024 reset SHALL take priority over restart and every other input, including mid-scroll and during RESPAWN.

Structure
REQ-025 A shared package flappy_pkg SHALL hold the following, so the collision checker and renderer use identical values:
  - the SCREEN_W, WALL_W and GAP_H defaults;
  - the hole top offset (8);
  - the FSM state encoding.
REQ-026 The LFSR SHALL be a separate sub-module lfsr8 with ports clk, reset, seed, q[7:0].
REQ-027 The FSM and position registers SHALL live in wall_scroller.

Verification
REQ-028 Reset and start: assert reset, then enable=1 with no ticks -> outputs 144/159/40/80, state SCROLL, wall_passed=0.
REQ-029 Scroll: enable=1, 10 frame_ticks -> wall_xleft=134 and wall_xright=149; enable=0 plus 5 ticks -> values unchanged.
REQ-030 Wrap: drive 144 ticks -> wall_xleft=0; next tick -> RESPAWN, then on the following cycle:
  - wall_xleft=144;
  - wall_passed pulses once;
  - 8 <= wall_topy <= 71;
  - wall_bottomy = wall_topy + 40.
REQ-031 Restart priority: restart and frame_tick in the same cycle at wall_xleft=50 -> wall_xleft=144, state IDLE, no wall_passed.
REQ-032 LFSR: after reset, run 255 clocks -> lfsr never 0 and returns to 8'hA5 at cycle 255; reset asserted during RESPAWN -> start values, no wall_passed.
